sram_bus_master: RTL and testbench

- Sequential bus-cycle initiator that generates 6809-style SRAM accesses toward the SRAM chip-select/strobe logic: address, sram_ce, R/W and an enable strobe with programmable setup, strobe and hold phases.
- Upstream, a simple req/ready/done handshake lets internal agents (boot loader, debug UART, DMA) read or write single bytes of SRAM.
- Sits between those agents and the SRAM strobe-generation block, in place of the CPU, while the CPU is held off the bus.

---
 rtl/sram_bus_pkg.sv | 30 +++
 rtl/sram_bus_master.sv | 122 ++++++++++++
 tb/tb_sram_bus_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_bus_pkg
// Description : Shared types and constants for the SRAM bus-cycle initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_bus_pkg;

  localparam int DATA_W = 8;

  // 6809 R/W polarity: high reads, low writes
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Largest of three phase lengths; sizes the shared phase counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : sram_bus_master
// Description : Single-byte SRAM bus-cycle initiator. Turns a req/ready/done
//               request into a 6809-style access with programmable setup,
//               strobe and hold phases. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_sram_ce,
  output logic              o_RW,
  output logic              o_enable,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_oe,
  input  logic [DATA_W-1:0] i_data
);

  localparam int c_max_cyc = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

  localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_setup_ld   = c_cnt_w'(SETUP_CYC);
  localparam logic [c_cnt_w-1:0] c_strobe_ld  = c_cnt_w'(STROBE_CYC);
  localparam logic [c_cnt_w-1:0] c_hold_ld    = c_cnt_w'(HOLD_CYC);

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;

  // Phase sequencer: each phase loads its length and counts down to 1;
  // bus outputs are updated on the edge that enters the next phase so they
  // are stable for the whole phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
      o_rdata   <= '0;
      o_addr    <= '0;
      o_sram_ce <= 1'b0;
      o_RW      <= RW_READ;
      o_enable  <= 1'b0;
      o_data    <= '0;
      o_data_oe <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req && o_ready) begin
            // Request fields are captured once; later input churn is ignored
            o_addr    <= i_addr;
            o_RW      <= i_rw;
            o_data    <= i_wdata;
            o_sram_ce <= 1'b1;
            o_data_oe <= (i_rw == RW_WRITE);
            o_ready   <= 1'b0;
            r_cnt     <= c_setup_ld;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == c_one) begin
            o_enable <= 1'b1;
            r_cnt    <= c_strobe_ld;
            r_state  <= STROBE;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        STROBE: begin
          if (r_cnt == c_one) begin
            // Read data is sampled on the edge that closes the strobe
            if (o_RW == RW_READ) begin
              o_rdata <= i_data;
            end
            o_enable <= 1'b0;
            r_cnt    <= c_hold_ld;
            r_state  <= HOLD;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        HOLD: begin
          if (r_cnt == c_one) begin
            // Release the bus; address and write data keep their last values
            o_sram_ce <= 1'b0;
            o_data_oe <= 1'b0;
            o_RW      <= RW_READ;
            o_done    <= 1'b1;
            o_ready   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bus_master
// Description : Self-checking bench for sram_bus_master. Instance A uses the
//               default timing (1/2/1), instance B uses 3/1/2. Expected bus
//               waveforms are derived from phase lengths per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bus_master;

  typedef struct packed {
    logic        ready;
    logic        done;
    logic        ce;
    logic        rw;
    logic        en;
    logic        oe;
    logic [7:0]  rdata;
    logic [7:0]  data;
    logic [15:0] addr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, rw;
  logic [15:0] addr;
  logic [7:0]  wdata, data_in;

  logic        a_ready, a_done, a_ce, a_RW, a_en, a_oe;
  logic [7:0]  a_rdata, a_data;
  logic [15:0] a_addr;
  logic        b_ready, b_done, b_ce, b_RW, b_en, b_oe;
  logic [7:0]  b_rdata, b_data;
  logic [15:0] b_addr;

  obs_t oa, ob;
  assign oa = {a_ready, a_done, a_ce, a_RW, a_en, a_oe, a_rdata, a_data, a_addr};
  assign ob = {b_ready, b_done, b_ce, b_RW, b_en, b_oe, b_rdata, b_data, b_addr};

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_rd [2];

  always #5 clk = ~clk;

  sram_bus_master #(.ADDR_W(16)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_rw(rw), .i_addr(addr),
    .i_wdata(wdata), .o_ready(a_ready), .o_done(a_done), .o_rdata(a_rdata),
    .o_addr(a_addr), .o_sram_ce(a_ce), .o_RW(a_RW), .o_enable(a_en),
    .o_data(a_data), .o_data_oe(a_oe), .i_data(data_in)
  );

  sram_bus_master #(.ADDR_W(16), .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_rw(rw), .i_addr(addr),
    .i_wdata(wdata), .o_ready(b_ready), .o_done(b_done), .o_rdata(b_rdata),
    .o_addr(b_addr), .o_sram_ce(b_ce), .o_RW(b_RW), .o_enable(b_en),
    .o_data(b_data), .o_data_oe(b_oe), .i_data(data_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input bit s);
    obs_t o;
    string nm;
    o  = s ? ob : oa;
    nm = s ? "B" : "A";
    check({nm, ".rst.ready"}, 32'(o.ready), 32'd1);
    check({nm, ".rst.done"},  32'(o.done),  32'd0);
    check({nm, ".rst.rdata"}, 32'(o.rdata), 32'd0);
    check({nm, ".rst.addr"},  32'(o.addr),  32'd0);
    check({nm, ".rst.ce"},    32'(o.ce),    32'd0);
    check({nm, ".rst.rw"},    32'(o.rw),    32'd1);
    check({nm, ".rst.en"},    32'(o.en),    32'd0);
    check({nm, ".rst.data"},  32'(o.data),  32'd0);
    check({nm, ".rst.oe"},    32'(o.oe),    32'd0);
  endtask

  task automatic idle_check(input bit s);
    obs_t o;
    string nm;
    @(negedge clk);
    o  = s ? ob : oa;
    nm = s ? "B" : "A";
    check({nm, ".idle.ce"},    32'(o.ce),    32'd0);
    check({nm, ".idle.en"},    32'(o.en),    32'd0);
    check({nm, ".idle.done"},  32'(o.done),  32'd0);
    check({nm, ".idle.ready"}, 32'(o.ready), 32'd1);
  endtask

  // One access: called at a negedge with the DUT idle. The expected bus
  // picture for cycle k after acceptance follows from the phase lengths.
  // With nxt set, the following request is raised during the first strobe
  // cycle and left pending so it is taken in the done cycle.
  task automatic run_txn(input bit s, input bit t_rw, input logic [15:0] t_addr,
                         input logic [7:0] t_wd, input logic [7:0] t_rd,
                         input bit nxt, input bit n_rw, input logic [15:0] n_addr,
                         input logic [7:0] n_wd, input bit churn);
    int S, T, H, N;
    obs_t o;
    string nm;
    bit e_ce, e_en, e_done;
    S  = s ? 3 : 1;
    T  = s ? 1 : 2;
    H  = s ? 2 : 1;
    N  = S + T + H;
    nm = s ? "B" : "A";
    o  = s ? ob : oa;
    check($sformatf("%s.pre.ready", nm), 32'(o.ready), 32'd1);
    rw = t_rw; addr = t_addr; wdata = t_wd;
    if (s) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      data_in = (k == S + T) ? t_rd : ~t_rd;
      if (nxt && k == S + 1) begin
        rw = n_rw; addr = n_addr; wdata = n_wd;
        if (s) req_b = 1'b1; else req_a = 1'b1;
      end else if (churn && !nxt) begin
        addr = 16'($urandom); wdata = 8'($urandom); rw = 1'($urandom);
      end
      o      = s ? ob : oa;
      e_ce   = (k <= N);
      e_en   = (k > S) && (k <= S + T);
      e_done = (k == N + 1);
      check($sformatf("%s.ce.k%0d", nm, k),    32'(o.ce),    32'(e_ce));
      check($sformatf("%s.en.k%0d", nm, k),    32'(o.en),    32'(e_en));
      check($sformatf("%s.done.k%0d", nm, k),  32'(o.done),  32'(e_done));
      check($sformatf("%s.ready.k%0d", nm, k), 32'(o.ready), 32'(e_done));
      check($sformatf("%s.oe.k%0d", nm, k),    32'(o.oe),    32'(e_ce && !t_rw));
      check($sformatf("%s.rw.k%0d", nm, k),    32'(o.rw),    32'(e_ce ? t_rw : 1'b1));
      check($sformatf("%s.addr.k%0d", nm, k),  32'(o.addr),  32'(t_addr));
      check($sformatf("%s.data.k%0d", nm, k),  32'(o.data),  32'(t_wd));
    end
    if (t_rw) ref_rd[s] = t_rd;
    check($sformatf("%s.rdata", nm), 32'(o.rdata), 32'(ref_rd[s]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit          c_rw, n_rw, b2b;
    logic [15:0] c_addr, n_addr;
    logic [7:0]  c_wd, n_wd;

    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; rw = 1'b1;
    addr = '0; wdata = '0; data_in = '0;
    ref_rd[0] = '0; ref_rd[1] = '0;
    repeat (2) @(negedge clk);
    check_reset_state(1'b0);
    check_reset_state(1'b1);
    rst_n = 1'b1;
    idle_check(1'b0);

    // Directed: default-timing write, read, back-to-back, input churn
    run_txn(1'b0, 1'b0, 16'h1234, 8'hA5, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    idle_check(1'b0);
    run_txn(1'b0, 1'b1, 16'h0100, 8'h00, 8'h3C, 1'b1, 1'b0, 16'hBEEF, 8'h77, 1'b0);
    run_txn(1'b0, 1'b0, 16'hBEEF, 8'h77, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    idle_check(1'b0);
    run_txn(1'b0, 1'b0, 16'h5A5A, 8'hC3, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
    idle_check(1'b0);

    // Directed: swept timing 3/1/2
    run_txn(1'b1, 1'b0, 16'h2222, 8'h11, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    idle_check(1'b1);
    run_txn(1'b1, 1'b1, 16'h3333, 8'h00, 8'h99, 1'b1, 1'b1, 16'h4321, 8'h5E, 1'b0);
    run_txn(1'b1, 1'b1, 16'h4321, 8'h5E, 8'h6D, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
    idle_check(1'b1);

    // Reset in the middle of a default-timing strobe
    rw = 1'b1; addr = 16'h4444; wdata = 8'hEE; req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(posedge clk);
    #2;
    check("A.midrst.en_before", 32'(a_en), 32'd1);
    rst_n = 1'b0;
    #1;
    ref_rd[0] = '0; ref_rd[1] = '0;
    check("A.midrst.en",    32'(a_en),    32'd0);
    check("A.midrst.ce",    32'(a_ce),    32'd0);
    check("A.midrst.oe",    32'(a_oe),    32'd0);
    check("A.midrst.rw",    32'(a_RW),    32'd1);
    check("A.midrst.ready", 32'(a_ready), 32'd1);
    check("A.midrst.done",  32'(a_done),  32'd0);
    repeat (2) begin
      @(negedge clk);
      check("A.midrst.hold_done", 32'(a_done), 32'd0);
    end
    rst_n = 1'b1;
    idle_check(1'b0);
    check("A.midrst.no_done", 32'(a_done), 32'd0);
    run_txn(1'b0, 1'b1, 16'h0ACE, 8'h00, 8'hD2, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    idle_check(1'b0);

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      c_rw = 1'($urandom); c_addr = 16'($urandom); c_wd = 8'($urandom);
      for (int i = 0; i < 10; i++) begin
        n_rw   = 1'($urandom);
        n_addr = 16'($urandom);
        n_wd   = 8'($urandom);
        b2b    = (i < 9) && ($urandom_range(0, 1) == 1);
        run_txn(1'(s), c_rw, c_addr, c_wd, 8'($urandom), b2b, n_rw, n_addr, n_wd,
                $urandom_range(0, 1) == 1);
        if (!b2b) repeat ($urandom_range(0, 2)) idle_check(1'(s));
        c_rw = n_rw; c_addr = n_addr; c_wd = n_wd;
      end
      idle_check(1'(s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
